// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one load/store at a time,
// served from a word array LATENCY cycles after acceptance, pipeline held on stall_o.
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       data_q, data_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];

  logic              req;
  logic              access;
  logic              aligned;
  logic              mem_we;
  logic [ADDR_W-1:0] idx;
  logic              unused_addr_hi;

  // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH words.
  assign unused_addr_hi = ^addr_i[31:ADDR_W+2];

  assign req     = MemRead_i | MemWrite_i;
  assign idx     = addr_q[ADDR_W+1:2];
  assign aligned = (addr_q[1:0] == 2'b00);
  assign access  = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign mem_we  = access & we_q & aligned;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    re_d    = re_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = MemWrite_i;
          re_d    = MemRead_i;
          addr_d  = addr_i[ADDR_W+1:0];
          wdat_d  = data_i;
          cnt_d   = CNT_INIT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          // Simultaneous read+write still commits the store but is flagged.
          err_d   = ~aligned | (we_q & re_q);
          if (re_q && !we_q && aligned) begin
            data_d = mem_q[idx];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // Unconditional return keeps a still-held request from being re-issued here.
        state_d = ST_IDLE;
        we_d    = 1'b0;
        re_d    = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= 32'd0;
      data_q  <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; a reset during BUSY forces IDLE so mem_we drops before any edge.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx] <= wdat_q;
    end
  end

  assign stall_o = (state_q == ST_BUSY) | ((state_q == ST_IDLE) & req & ~rst_i);
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign data_o  = data_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the CPU's MEM-stage load/store interface.
- Accepts one MemRead or MemWrite request at a time from the EX/MEM pipeline register.
- Serves the request from an internal word array after a fixed, configurable latency.
- Holds the pipeline with stall_o until the access completes; replaces the single-cycle Data_Memory for multi-cycle memory timing.

Parameters:
- DEPTH, 32: number of 32-bit words in the array; power of two.
- ADDR_W, 5: word-index width, log2(DEPTH).
- LATENCY, 2: BUSY cycles per access; legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- MemRead_i  input  1  load request from EX/MEM.
- MemWrite_i  input  1  store request from EX/MEM.
- addr_i  input  32  byte address (ALU result).
- data_i  input  32  store data.
- data_o  output  32  load data, registered.
- stall_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM while high.
- ack_o  output  1  one-cycle access-complete pulse.
- err_o  output  1  one-cycle error pulse, coincident with ack_o.

Behaviour:
- Reset is asynchronous and active-high on rst_i, single clock clk_i.
- Reset values: state=IDLE, cnt=0, data_o=0, stall_o=0, ack_o=0, err_o=0, latched request cleared. The array is not reset.
- req = MemRead_i | MemWrite_i.
- States are IDLE, BUSY and DONE.
- IDLE:
  - stall_o = req (combinational), so the CPU freezes in the same cycle the request appears.
  - On a clock edge with req=1: latch we=MemWrite_i, re=MemRead_i, addr_i and data_i; set cnt=LATENCY-1; go to BUSY.
- BUSY:
  - stall_o=1.
  - Inputs are ignored; only the latched copy is used.
  - cnt decrements each edge. On the edge where cnt==0, perform the access and go to DONE.
- DONE:
  - stall_o=0, ack_o=1, data_o valid. The CPU advances on this edge.
  - Always returns to IDLE next edge, even if req is still asserted. This prevents re-issuing the held request.
  - A new request is recognised from the following IDLE cycle.
- Timing: a request first visible in cycle 0 gives stall cycles 0..LATENCY and ack in cycle LATENCY+1. Total stall is LATENCY+1 cycles.
- Index: addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Store: mem[index] <= data at the BUSY->DONE edge. data_o is unchanged.
- Load: data_o <= mem[index] at the same edge. data_o holds its value until the next completed load.
- Misaligned access (addr[1:0] != 0): no array read or write, data_o unchanged, err_o=1 with ack_o.
- Both MemRead_i and MemWrite_i latched high: the store is performed, data_o is unchanged, err_o=1.
- Load immediately after a store to the same word returns the new data, since the accesses are serialised.
- Reset mid-access:
  - Returns to IDLE immediately and drops stall_o.
  - A pending store is aborted, with no array write.
  - A store already committed in an earlier DONE is kept.
- ack_o and err_o are never high outside DONE.
- stall_o and ack_o are never high together.

Test Plan:
- Reset then store: rst_i pulse, then MemWrite_i=1, addr=0x8, data=0xDEADBEEF held until ack (LATENCY=2) -> stall_o high for exactly 3 cycles, ack_o pulses in cycle 3, err_o=0.
- Load back: MemRead_i=1, addr=0x8 -> data_o=0xDEADBEEF in the ack cycle and held afterwards; stall_o 3 cycles.
- Held request after ack: keep MemRead_i=1 for 2 more cycles after ack -> exactly one new access begins in the IDLE cycle after DONE, not in the DONE cycle itself.
- Wrap: store 0x12345678 to 0x80 with DEPTH=32, then load 0x0 -> data_o=0x12345678.
- Misaligned: store 0xAAAA5555 to 0x0A -> err_o=1 with ack_o; a later load of 0x08 still returns 0xDEADBEEF.
- Async reset mid-store: assert rst_i during the BUSY cycle of a store of 0x11111111 to 0x10 -> stall_o=0 immediately, no ack_o; a later load of 0x10 returns the prior contents.
